// File: rtl/vx_commit_counters.sv
// vx_commit_counters: the core's 64-bit mcycle and minstret counters.
// They are fed by the commit stage's per-cycle summary and exposed to the
// CSR unit as four 32-bit halves. Each counter has a hi-half shadow so that
// a lo read followed by a hi read returns one coherent 64-bit value.
//
// Read handshake: csr_rd_req is accepted every cycle, because there is no
// ready signal. A request in cycle N sets csr_rd_valid high in cycle N+1,
// together with csr_rd_data. The data is the counter value at the start of
// cycle N. csr_rd_valid stays high for exactly one cycle per request.
// A request made while reset is high is discarded.
module vx_commit_counters #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_SOURCES = 5,
  parameter int SIZE_W      = $clog2(NUM_SOURCES * NUM_THREADS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmt_valid,
  input  logic [SIZE_W-1:0] cmt_size,
  input  logic [1:0]        inhibit,
  input  logic              csr_wr_valid,
  input  logic [1:0]        csr_wr_sel,
  input  logic [31:0]       csr_wr_data,
  input  logic              csr_rd_req,
  input  logic [1:0]        csr_rd_sel,
  output logic              csr_rd_valid,
  output logic [31:0]       csr_rd_data,
  output logic [63:0]       instret_out
);

  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic [31:0] cy_shadow;
  logic [31:0] ir_shadow;
  logic        cy_snap_vld;
  logic        ir_snap_vld;

  logic [63:0] mcycle_next;
  logic [63:0] minstret_next;
  logic [31:0] rd_mux;
  logic        wr_cy;
  logic        wr_ir;
  logic        rd_cy_lo;
  logic        rd_cy_hi;
  logic        rd_ir_lo;
  logic        rd_ir_hi;

  assign wr_cy    = csr_wr_valid && !csr_wr_sel[1];
  assign wr_ir    = csr_wr_valid &&  csr_wr_sel[1];
  assign rd_cy_lo = csr_rd_req && (csr_rd_sel == 2'd0);
  assign rd_cy_hi = csr_rd_req && (csr_rd_sel == 2'd1);
  assign rd_ir_lo = csr_rd_req && (csr_rd_sel == 2'd2);
  assign rd_ir_hi = csr_rd_req && (csr_rd_sel == 2'd3);

  // Next counter values: a CSR write replaces one half and blocks that counter's increment.
  always_comb begin
    mcycle_next   = mcycle;
    minstret_next = minstret;
    if (wr_cy) begin
      if (csr_wr_sel[0]) mcycle_next[63:32] = csr_wr_data;
      else               mcycle_next[31:0]  = csr_wr_data;
    end else if (!inhibit[0]) begin
      mcycle_next = mcycle + 64'd1;
    end
    if (wr_ir) begin
      if (csr_wr_sel[0]) minstret_next[63:32] = csr_wr_data;
      else               minstret_next[31:0]  = csr_wr_data;
    end else if (cmt_valid && !inhibit[1]) begin
      minstret_next = minstret + {{(64-SIZE_W){1'b0}}, cmt_size};
    end
  end

  // Read mux on pre-update state; a hi half reads the shadow while a snapshot is pending.
  always_comb begin
    rd_mux = 32'd0;
    case (csr_rd_sel)
      2'd0: rd_mux = mcycle[31:0];
      2'd1: rd_mux = cy_snap_vld ? cy_shadow : mcycle[63:32];
      2'd2: rd_mux = minstret[31:0];
      2'd3: rd_mux = ir_snap_vld ? ir_shadow : minstret[63:32];
      default: rd_mux = 32'd0;
    endcase
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle   <= 64'd0;
      minstret <= 64'd0;
    end else begin
      mcycle   <= mcycle_next;
      minstret <= minstret_next;
    end
  end

  // Snapshot state: a lo read arms the shadow, a hi read consumes it, a write to the counter cancels it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cy_shadow   <= 32'd0;
      ir_shadow   <= 32'd0;
      cy_snap_vld <= 1'b0;
      ir_snap_vld <= 1'b0;
    end else begin
      if (rd_cy_lo) cy_shadow <= mcycle[63:32];
      if (rd_ir_lo) ir_shadow <= minstret[63:32];
      if (wr_cy)         cy_snap_vld <= 1'b0;
      else if (rd_cy_lo) cy_snap_vld <= 1'b1;
      else if (rd_cy_hi) cy_snap_vld <= 1'b0;
      if (wr_ir)         ir_snap_vld <= 1'b0;
      else if (rd_ir_lo) ir_snap_vld <= 1'b1;
      else if (rd_ir_hi) ir_snap_vld <= 1'b0;
    end
  end

  // Registered read response, one cycle after the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      csr_rd_valid <= 1'b0;
      csr_rd_data  <= 32'd0;
    end else begin
      csr_rd_valid <= csr_rd_req;
      if (csr_rd_req) csr_rd_data <= rd_mux;
    end
  end

  assign instret_out = minstret;

endmodule

// File: tb/tb_vx_commit_counters.sv
// Bench for vx_commit_counters: a table of write/read vectors, hand-written
// corner sequences and a randomized phase. Every cycle is checked against a
// 64-bit arithmetic model of the counters.
module tb_vx_commit_counters;
  localparam int SIZE_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmt_valid;
  logic [SIZE_W-1:0] cmt_size;
  logic [1:0]        inhibit;
  logic              csr_wr_valid;
  logic [1:0]        csr_wr_sel;
  logic [31:0]       csr_wr_data;
  logic              csr_rd_req;
  logic [1:0]        csr_rd_sel;
  logic              csr_rd_valid;
  logic [31:0]       csr_rd_data;
  logic [63:0]       instret_out;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [63:0] m_cy, m_ir;
  logic [31:0] m_cy_sh, m_ir_sh;
  bit          m_cy_sv, m_ir_sv;
  bit          m_rd_valid;
  bit          m_was_reset;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;
    logic [1:0]  rd_sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  vx_commit_counters #(.NUM_THREADS(4), .NUM_SOURCES(5), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .reset(reset), .cmt_valid(cmt_valid), .cmt_size(cmt_size),
    .inhibit(inhibit), .csr_wr_valid(csr_wr_valid), .csr_wr_sel(csr_wr_sel),
    .csr_wr_data(csr_wr_data), .csr_rd_req(csr_rd_req), .csr_rd_sel(csr_rd_sel),
    .csr_rd_valid(csr_rd_valid), .csr_rd_data(csr_rd_data), .instret_out(instret_out)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model update for one clock edge, using the inputs held during the cycle.
  task automatic model_edge();
    logic [63:0] cy_n, ir_n;
    if (reset) begin
      m_cy = 0; m_ir = 0; m_cy_sh = 0; m_ir_sh = 0;
      m_cy_sv = 0; m_ir_sv = 0; m_rd_valid = 0; m_was_reset = 1;
      exp_q.delete();
      return;
    end
    m_was_reset = 0;
    m_rd_valid = csr_rd_req;
    if (csr_rd_req) begin
      case (csr_rd_sel)
        2'd0: exp_q.push_back(m_cy[31:0]);
        2'd1: exp_q.push_back(m_cy_sv ? m_cy_sh : m_cy[63:32]);
        2'd2: exp_q.push_back(m_ir[31:0]);
        default: exp_q.push_back(m_ir_sv ? m_ir_sh : m_ir[63:32]);
      endcase
    end
    cy_n = inhibit[0] ? m_cy : m_cy + 64'd1;
    ir_n = (cmt_valid && !inhibit[1]) ? m_ir + 64'(cmt_size) : m_ir;
    if (csr_wr_valid) begin
      case (csr_wr_sel)
        2'd0: cy_n = {m_cy[63:32], csr_wr_data};
        2'd1: cy_n = {csr_wr_data, m_cy[31:0]};
        2'd2: ir_n = {m_ir[63:32], csr_wr_data};
        default: ir_n = {csr_wr_data, m_ir[31:0]};
      endcase
    end
    if (csr_rd_req && csr_rd_sel == 2'd0) begin m_cy_sh = m_cy[63:32]; m_cy_sv = 1; end
    else if (csr_rd_req && csr_rd_sel == 2'd1) m_cy_sv = 0;
    if (csr_rd_req && csr_rd_sel == 2'd2) begin m_ir_sh = m_ir[63:32]; m_ir_sv = 1; end
    else if (csr_rd_req && csr_rd_sel == 2'd3) m_ir_sv = 0;
    if (csr_wr_valid && !csr_wr_sel[1]) m_cy_sv = 0;
    if (csr_wr_valid &&  csr_wr_sel[1]) m_ir_sv = 0;
    m_cy = cy_n;
    m_ir = ir_n;
  endtask

  // One clock cycle: advance the model at the edge, then compare outputs 1 ns later.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    model_edge();
    #1;
    check("rd_valid", csr_rd_valid, m_rd_valid);
    if (m_rd_valid) begin
      e = exp_q.pop_front();
      check("rd_data", csr_rd_data, e);
    end
    if (m_was_reset) check("rd_data_reset", csr_rd_data, 0);
    check("instret_out", instret_out, m_ir);
  endtask

  task automatic set_idle();
    cmt_valid = 0; cmt_size = 0; csr_wr_valid = 0; csr_wr_sel = 0;
    csr_wr_data = 0; csr_rd_req = 0; csr_rd_sel = 0;
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [31:0] data);
    csr_wr_valid = 1; csr_wr_sel = sel; csr_wr_data = data;
    tick();
    csr_wr_valid = 0;
  endtask

  task automatic do_read(input string name, input logic [1:0] sel, input logic [31:0] exp);
    csr_rd_req = 1; csr_rd_sel = sel;
    tick();
    csr_rd_req = 0;
    check(name, csr_rd_data, exp);
  endtask

  initial begin
    vecs[0] = '{1, 2'd0, 32'h0000_1234, 2'd0, 32'h0000_1234};
    vecs[1] = '{1, 2'd1, 32'h0000_ABCD, 2'd1, 32'h0000_ABCD};
    vecs[2] = '{1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'hFFFF_FFFF};
    vecs[3] = '{1, 2'd3, 32'h0000_0007, 2'd3, 32'h0000_0007};
    vecs[4] = '{0, 2'd0, 32'h0,         2'd0, 32'h0000_1234};
    vecs[5] = '{1, 2'd1, 32'h0000_5555, 2'd1, 32'h0000_5555};
    vecs[6] = '{0, 2'd0, 32'h0,         2'd2, 32'hFFFF_FFFF};
    vecs[7] = '{0, 2'd0, 32'h0,         2'd3, 32'h0000_0007};

    set_idle();
    inhibit = 2'b00;
    reset = 1;
    csr_rd_req = 1;
    tick(); tick();
    csr_rd_req = 0;
    reset = 0;

    // Idle count: the request cycle index is the mcycle value read back.
    repeat (10) tick();
    do_read("mcycle_after_10", 2'd0, 32'd10);
    check("rd_valid_pulse", csr_rd_valid, 1);
    do_read("minstret_zero", 2'd2, 32'd0);
    tick();
    check("rd_valid_drop", csr_rd_valid, 0);

    // Commit accumulation and the instret inhibit.
    cmt_valid = 1; cmt_size = 20;
    tick();
    check("instret_first", instret_out, 64'd20);
    cmt_size = 7; tick();
    cmt_size = 0; tick();
    cmt_valid = 0;
    check("instret_27", instret_out, 64'd27);
    inhibit = 2'b10; cmt_valid = 1; cmt_size = 5;
    tick();
    cmt_valid = 0; tick();
    check("instret_inhibited", instret_out, 64'd27);
    inhibit = 2'b00;

    // Carry from lo into hi, and mcycle wrap.
    do_write(2'd2, 32'hFFFF_FFFF);
    do_write(2'd3, 32'h0);
    cmt_valid = 1; cmt_size = 2; tick(); cmt_valid = 0;
    check("instret_carry", instret_out, 64'h1_0000_0001);
    do_write(2'd1, 32'hFFFF_FFFF);
    do_write(2'd0, 32'hFFFF_FFFF);
    tick();
    do_read("mcycle_wrap", 2'd0, 32'd0);

    // A write wins over a same-cycle commit.
    cmt_valid = 1; cmt_size = 4;
    do_write(2'd2, 32'h100);
    cmt_valid = 0;
    check("write_beats_commit", instret_out, 64'h1_0000_0100);

    // Hi snapshot across a carry.
    do_write(2'd2, 32'hFFFF_FFFE);
    do_write(2'd3, 32'h0);
    do_read("snap_lo", 2'd2, 32'hFFFF_FFFE);
    cmt_valid = 1; cmt_size = 4; tick(); cmt_valid = 0;
    do_read("snap_hi", 2'd3, 32'h0);
    do_read("live_hi", 2'd3, 32'h1);

    // Table of write-then-read vectors with both counters frozen.
    inhibit = 2'b11;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) do_write(vecs[i].wr_sel, vecs[i].wr_data);
      do_read($sformatf("vec%0d", i), vecs[i].rd_sel, vecs[i].exp);
    end

    // A same-cycle write cancels the snapshot the lo read would have armed.
    csr_wr_valid = 1; csr_wr_sel = 2'd3; csr_wr_data = 32'h9;
    do_read("rd_wr_same_cycle", 2'd2, 32'hFFFF_FFFF);
    csr_wr_valid = 0;
    do_read("hi_live_after_wr", 2'd3, 32'h9);
    csr_wr_valid = 1; csr_wr_sel = 2'd2; csr_wr_data = 32'h42;
    do_read("rd_pre_write", 2'd2, 32'hFFFF_FFFF);
    csr_wr_valid = 0;
    do_read("rd_post_write", 2'd2, 32'h42);
    inhibit = 2'b00;

    // Reset wins over a pending read.
    do_write(2'd2, 32'h55);
    do_write(2'd3, 32'h0);
    reset = 1; csr_rd_req = 1; csr_rd_sel = 2'd2;
    tick();
    check("reset_kills_read", csr_rd_valid, 0);
    reset = 0; csr_rd_req = 0;
    check("instret_reset", instret_out, 0);
    do_read("post_reset_cy_lo", 2'd0, 32'd0);
    do_read("post_reset_ir_lo", 2'd2, 32'd0);
    do_read("post_reset_ir_hi", 2'd3, 32'd0);
    do_read("post_reset_cy_hi", 2'd1, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 199) == 0);
      cmt_valid    = $urandom_range(0, 1);
      cmt_size     = SIZE_W'($urandom_range(0, 20));
      inhibit      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      csr_wr_valid = ($urandom_range(0, 7) == 0);
      csr_wr_sel   = 2'($urandom_range(0, 3));
      csr_wr_data  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      csr_rd_req   = $urandom_range(0, 1);
      csr_rd_sel   = 2'($urandom_range(0, 3));
      tick();
    end
    set_idle();
    reset = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
